// File: rtl/machine_mode_types_1_12_pkg.sv
// -----------------------------------------------------------------------------
// machine_mode_types_1_12_pkg
// Shared M-mode CSR field layouts and cause codes (privileged ISA 1.12).
// Types: mtvec_mode_e, mtvec_t, mcause_t, mip_t, mie_t, ex_code_t, int_code_t.
// -----------------------------------------------------------------------------
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1,
    MTVEC_RES_0    = 2'd2,
    MTVEC_RES_1    = 2'd3
  } mtvec_mode_e;

  typedef struct packed {
    logic [29:0] base;
    mtvec_mode_e mode;
  } mtvec_t;

  typedef struct packed {
    logic        interrupt;
    logic [30:0] code;
  } mcause_t;

  // Bit 16 (debug) lives inside the platform field and is deliberately unused.
  typedef struct packed {
    logic [15:0] platform;
    logic [3:0]  rsvd_15_12;
    logic        meip;
    logic        rsvd_10;
    logic        seip;
    logic        rsvd_8;
    logic        mtip;
    logic        rsvd_6;
    logic        stip;
    logic        rsvd_4;
    logic        msip;
    logic        rsvd_2;
    logic        ssip;
    logic        rsvd_0;
  } mip_t;

  // mie has the same bit layout as mip (enable bit sits on the pending bit).
  typedef mip_t mie_t;

  typedef enum logic [30:0] {
    EXC_INSN_MISALIGNED  = 31'd0,
    EXC_INSN_ACCESS      = 31'd1,
    EXC_ILLEGAL_INSN     = 31'd2,
    EXC_BREAKPOINT       = 31'd3,
    EXC_LOAD_MISALIGNED  = 31'd4,
    EXC_LOAD_ACCESS      = 31'd5,
    EXC_STORE_MISALIGNED = 31'd6,
    EXC_STORE_ACCESS     = 31'd7,
    EXC_ECALL_U          = 31'd8,
    EXC_ECALL_S          = 31'd9,
    EXC_ECALL_M          = 31'd11,
    EXC_INSN_PAGE_FAULT  = 31'd12,
    EXC_LOAD_PAGE_FAULT  = 31'd13,
    EXC_STORE_PAGE_FAULT = 31'd15
  } ex_code_t;

  typedef enum logic [30:0] {
    INT_SSI = 31'd1,
    INT_MSI = 31'd3,
    INT_STI = 31'd5,
    INT_MTI = 31'd7,
    INT_SEI = 31'd9,
    INT_MEI = 31'd11
  } int_code_t;

endpackage

// File: rtl/trap_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trap_seq_pkg
// Sequencer state and trap-kind types, plus the redirect-target helper.
// -----------------------------------------------------------------------------
package trap_seq_pkg;
  import machine_mode_types_1_12_pkg::*;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EXC  = 2'd0,
    INT  = 2'd1,
    MRET = 2'd2
  } trap_kind_t;

  // Fetch target after the commit. Only interrupts are vectored; reserved
  // mtvec modes fall back to DIRECT. 4*cause is taken modulo 2^32.
  function automatic logic [31:0] trap_target(
    input trap_kind_t  kind,
    input mtvec_t      mtvec,
    input logic [29:0] code_lo,
    input logic [31:0] mepc,
    input logic        vectored_en
  );
    logic [31:0] base_addr;
    base_addr = {mtvec.base, 2'b00};
    if (kind == MRET)
      trap_target = mepc & ~32'h3;
    else if (kind == INT && vectored_en && mtvec.mode == MTVEC_VECTORED)
      trap_target = base_addr + {code_lo, 2'b00};
    else
      trap_target = base_addr;
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// -----------------------------------------------------------------------------
// trap_sequencer_if
// Fetch-redirect handshake between the trap sequencer and the fetch unit.
//   redirect_valid : sequencer -> fetch, target is valid
//   redirect_pc    : sequencer -> fetch, target address (stable while valid)
//   redirect_ready : fetch -> sequencer, target accepted
// -----------------------------------------------------------------------------
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_sequencer_int_prio.sv
// -----------------------------------------------------------------------------
// trap_int_prio
// Fixed-priority M-mode interrupt encoder: MEI > MSI > MTI > SEI > SSI > STI.
//   pend_i  : mip & mie
//   en_i    : global interrupt enable (mstatus.MIE)
//   valid_o : an enabled interrupt is pending
//   code_o  : winning interrupt code (don't care when valid_o is 0)
// -----------------------------------------------------------------------------
module trap_int_prio
  import machine_mode_types_1_12_pkg::*;
(
  input  mip_t      pend_i,
  input  logic      en_i,
  output logic      valid_o,
  output int_code_t code_o
);

  // NOTE: every output gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_o = 1'b0;
    code_o  = INT_STI;
    if (en_i) begin
      valid_o = 1'b1;
      if      (pend_i.meip) code_o = INT_MEI;
      else if (pend_i.msip) code_o = INT_MSI;
      else if (pend_i.mtip) code_o = INT_MTI;
      else if (pend_i.seip) code_o = INT_SEI;
      else if (pend_i.ssip) code_o = INT_SSI;
      else if (pend_i.stip) code_o = INT_STI;
      else                  valid_o = 1'b0;
    end
  end

  // Debug, platform and reserved bits never raise a trap.
  logic unused_bits;
  assign unused_bits = ^{pend_i.platform, pend_i.rsvd_15_12, pend_i.rsvd_10,
                         pend_i.rsvd_8, pend_i.rsvd_6, pend_i.rsvd_4,
                         pend_i.rsvd_2, pend_i.rsvd_0};

endmodule

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
// M-mode trap controller: takes an exception, interrupt or MRET, drains the
// pipeline, pulses one CSR commit, then redirects fetch.
//   CLK, RST                 : clock, asynchronous active-high reset
//   ex_*_i                   : exception from the oldest instruction
//   int_epc_i                : mepc used for interrupts
//   mret_i                   : MRET at commit
//   mip_i, mie_i, mstatus_mie_i : interrupt sources and enables
//   mtvec_i, mepc_i          : current CSR values
//   pipe_flush_o/pipe_drained_i : pipeline drain handshake
//   trap_commit_o, mcause_o, mepc_o, mtval_o : trap CSR update (COMMIT only)
//   mret_commit_o            : MRET CSR update (COMMIT only)
//   redir                    : fetch redirect (valid/pc/ready)
//   busy_o                   : sequence in progress
// -----------------------------------------------------------------------------
module trap_sequencer
  import machine_mode_types_1_12_pkg::*;
  import trap_seq_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int VECTORED_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ex_valid_i,
  input  ex_code_t          ex_cause_i,
  input  logic [XLEN-1:0]   ex_epc_i,
  input  logic [XLEN-1:0]   ex_tval_i,
  input  logic [XLEN-1:0]   int_epc_i,
  input  logic              mret_i,
  input  mip_t              mip_i,
  input  mie_t              mie_i,
  input  logic              mstatus_mie_i,
  input  mtvec_t            mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  output logic              pipe_flush_o,
  input  logic              pipe_drained_i,
  output logic              trap_commit_o,
  output mcause_t           mcause_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic [XLEN-1:0]   mtval_o,
  output logic              mret_commit_o,
  trap_sequencer_if.master  redir,
  output logic              busy_o
);

  state_e          state_q;
  trap_kind_t      kind_q;
  mcause_t         cause_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] tval_q;

  logic            pipe_flush_q;
  logic            trap_commit_q;
  logic            mret_commit_q;
  mcause_t         mcause_out_q;
  logic [XLEN-1:0] mepc_out_q;
  logic [XLEN-1:0] mtval_out_q;
  logic            redir_valid_q;
  logic [XLEN-1:0] redir_pc_q;
  logic            busy_q;

  mip_t            pend;
  logic            int_valid;
  int_code_t       int_code;
  logic [XLEN-1:0] target_d;

  assign pend = mip_t'(mip_i & mie_i);

  trap_int_prio u_int_prio (
    .pend_i  (pend),
    .en_i    (mstatus_mie_i),
    .valid_o (int_valid),
    .code_o  (int_code)
  );

  // Sampled during COMMIT, so mtvec/mepc are read once the pipeline is quiet.
  assign target_d = trap_target(kind_q, mtvec_i, cause_q.code[29:0], mepc_i,
                                VECTORED_EN != 0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      kind_q        <= EXC;
      cause_q       <= '0;
      epc_q         <= '0;
      tval_q        <= '0;
      pipe_flush_q  <= 1'b0;
      trap_commit_q <= 1'b0;
      mret_commit_q <= 1'b0;
      mcause_out_q  <= '0;
      mepc_out_q    <= '0;
      mtval_out_q   <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      // Commit outputs are single-cycle; clear them unless COMMIT is entered.
      trap_commit_q <= 1'b0;
      mret_commit_q <= 1'b0;
      mcause_out_q  <= '0;
      mepc_out_q    <= '0;
      mtval_out_q   <= '0;

      case (state_q)
        IDLE: begin
          if (ex_valid_i || mret_i || int_valid) begin
            state_q      <= FLUSH;
            pipe_flush_q <= 1'b1;
            busy_q       <= 1'b1;
          end
          if (ex_valid_i) begin
            kind_q            <= EXC;
            cause_q.interrupt <= 1'b0;
            cause_q.code      <= ex_cause_i;
            epc_q             <= ex_epc_i;
            tval_q            <= ex_tval_i;
          end else if (mret_i) begin
            kind_q <= MRET;
          end else if (int_valid) begin
            kind_q            <= INT;
            cause_q.interrupt <= 1'b1;
            cause_q.code      <= int_code;
            epc_q             <= int_epc_i;
            tval_q            <= '0;
          end
        end

        FLUSH: begin
          if (pipe_drained_i) begin
            state_q      <= COMMIT;
            pipe_flush_q <= 1'b0;
            if (kind_q == MRET) begin
              mret_commit_q <= 1'b1;
            end else begin
              trap_commit_q <= 1'b1;
              mcause_out_q  <= cause_q;
              mepc_out_q    <= epc_q;
              mtval_out_q   <= tval_q;
            end
          end
        end

        COMMIT: begin
          state_q       <= REDIRECT;
          redir_valid_q <= 1'b1;
          redir_pc_q    <= target_d;
        end

        REDIRECT: begin
          if (redir.redirect_ready) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            busy_q        <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign pipe_flush_o         = pipe_flush_q;
  assign trap_commit_o        = trap_commit_q;
  assign mret_commit_o        = mret_commit_q;
  assign mcause_o             = mcause_out_q;
  assign mepc_o               = mepc_out_q;
  assign mtval_o              = mtval_out_q;
  assign redir.redirect_valid = redir_valid_q;
  assign redir.redirect_pc    = redir_pc_q;
  assign busy_o               = busy_q;

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
M-mode trap controller for the priv-1.12 CSR file.
- Detects synchronous exceptions, enabled pending interrupts and MRET.
- Drains the pipeline, then issues one CSR commit pulse (mcause/mepc/mtval/mstatus update).
- Redirects fetch to the trap vector or mepc through a valid/ready handshake.
- Sits between the execute stage, the CSR file and the fetch unit.

Parameters:
XLEN, 32, data/address width (only 32 supported).
VECTORED_EN, 1, 1 = honour mtvec.mode VECTORED; 0 = always DIRECT.

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
ex_valid_i  in  1  exception raised by the oldest instruction
ex_cause_i  in  31  exception code (ex_code_t)
ex_epc_i  in  32  PC of the faulting instruction
ex_tval_i  in  32  trap value
int_epc_i  in  32  PC of the next unretired instruction (interrupt mepc)
mret_i  in  1  MRET reached commit
mip_i  in  32  mip_t
mie_i  in  32  mie_t
mstatus_mie_i  in  1  global M-mode interrupt enable
mtvec_i  in  32  mtvec_t
mepc_i  in  32  current mepc
pipe_flush_o  out  1  request pipeline drain
pipe_drained_i  in  1  pipeline empty
trap_commit_o  out  1  one-cycle pulse: CSR file loads mcause/mepc/mtval; MPIE<=MIE, MIE<=0, MPP<=M
mcause_o  out  32  mcause_t value
mepc_o  out  32  mepc value
mtval_o  out  32  mtval value
mret_commit_o  out  1  one-cycle pulse: MIE<=MPIE, MPIE<=1
redirect_valid_o  out  1  fetch redirect request
redirect_pc_o  out  32  redirect target
redirect_ready_i  in  1  fetch accepts redirect
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, RST=1): state IDLE; all outputs 0; captured registers cleared. RST asserted mid-sequence aborts immediately, with no commit or redirect.
- Interrupt pending vector: pend = mip_i & mie_i, qualified by mstatus_mie_i.
- Priority, high to low: MEI(11), MSI(3), MTI(7), SEI(9), SSI(1), STI(5). Debug (16) and impl-defined bits are ignored.
- Event priority in IDLE, same cycle: ex_valid_i > mret_i > interrupt.
- IDLE: on an event, capture kind (EXC/INT/MRET) plus cause, epc, tval, and go to FLUSH.
  - EXC: cause = ex_cause_i, epc = ex_epc_i, tval = ex_tval_i.
  - INT: cause = winning int_code_t, interrupt bit = 1, epc = int_epc_i, tval = 0.
  - MRET: nothing beyond kind.
- FLUSH: pipe_flush_o = 1; stay until pipe_drained_i = 1, then go to COMMIT. pipe_flush_o drops on the COMMIT cycle.
- COMMIT: exactly one cycle.
  - EXC/INT: trap_commit_o = 1 with mcause_o/mepc_o/mtval_o driven from the capture.
  - MRET: mret_commit_o = 1.
  - Target computed and registered here:
    - MRET: mepc_i & ~3.
    - INT with VECTORED_EN=1 and mtvec.mode=VECTORED: {base,2'b00} + 4*cause (32-bit wrap).
    - Otherwise: {base,2'b00]. Mode RES_0/RES_1 is treated as DIRECT.
  - Next state: REDIRECT.
- REDIRECT: redirect_valid_o = 1; redirect_pc_o is stable while valid. On redirect_ready_i = 1: valid drops next cycle and state returns to IDLE. If ready is already high on the first REDIRECT cycle, that is a one-cycle handshake.
- Inputs are ignored outside IDLE. Sources must hold or re-raise the event; interrupts are level-sampled and re-evaluated in IDLE.
- Commit outputs are 0 except in COMMIT. mcause_o/mepc_o/mtval_o are 0 outside COMMIT.
- Latency with pipe_drained_i already high and ready high: event at cycle 0, FLUSH at 1, COMMIT at 2, redirect_valid at 3, IDLE at 4.

Decomposition:
- trap_seq_pkg: state enum (IDLE, FLUSH, COMMIT, REDIRECT) and trap_kind_t (EXC, INT, MRET).
- Reuse mcause_t, mtvec_t, mip_t, mie_t, ex_code_t and int_code_t from machine_mode_types_1_12_pkg.
- Sub-module trap_int_prio: combinational encoder from pend (mip & mie) plus the enable to {valid, int_code_t}.

Test Plan:
- Illegal insn: ex_valid=1, cause=2, epc=0x8000_0010, tval=0xDEAD_BEEF, mtvec=0x8000_0101 (vectored) -> trap_commit at cycle 2 with mcause=0x0000_0002, mepc=0x8000_0010, mtval=0xDEADBEEF; redirect_pc=0x8000_0100 (exceptions are not vectored).
- MTI and MEI both pending, enabled, mstatus_mie=1, mtvec=0x8000_0101 -> mcause=0x8000_000B, mtval=0, redirect_pc=0x8000_012C.
- Same-cycle ex_valid and mret_i with MSI pending -> exception commit only; mret_commit_o stays 0.
- MRET with mepc_i=0x8000_0203 -> mret_commit_o pulse; redirect_pc=0x8000_0200.
- pipe_drained_i low for 5 cycles, redirect_ready_i low for 3 cycles -> pipe_flush_o held 5 cycles, redirect_valid/pc stable 4 cycles, exactly one commit pulse.
- RST asserted during FLUSH -> outputs 0 immediately and no commit; after release, IDLE accepts a new interrupt normally; mstatus_mie_i=0 with pending MEI -> no sequence started.
